// File: rtl/cnn_layer_accel_pe_output_arbiter_pkg.sv
// rtl/cnn_layer_accel_pe_output_arbiter_pkg.sv - shared flit field positions and lock state type
package cnn_layer_accel_pe_output_arbiter_pkg;

  localparam int C_PKT_HEAD_BIT = 65;
  localparam int C_PKT_TAIL_BIT = 64;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_t;

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// rtl/cnn_layer_accel_rr_arb.sv - combinational round-robin picker, priority starts at ptr+1
module cnn_layer_accel_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          pos;
  logic [IW-1:0] lane;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    lane  = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      lane = IW'(pos);
      if (!any && req[lane]) begin
        any         = 1'b1;
        grant[lane] = 1'b1;
        idx         = lane;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_pe_output_arbiter.sv
// rtl/cnn_layer_accel_pe_output_arbiter.sv - packet-atomic round-robin merge of PE output lanes
module cnn_layer_accel_pe_output_arbiter
  import cnn_layer_accel_pe_output_arbiter_pkg::*;
#(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [C_NUM_PE-1:0]                pe_output_valid,
  output logic [C_NUM_PE-1:0]                pe_output_accept,
  input  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] pe_output_data,
  output logic                               arb_output_valid,
  input  logic                               arb_output_accept,
  output logic [C_PACKET_WIDTH-1:0]          arb_output_data,
  output logic [$clog2(C_NUM_PE)-1:0]        arb_output_grant,
  output logic                               arb_err_no_head
);

  localparam int GW = $clog2(C_NUM_PE);

  lock_t                     lock;
  logic [GW-1:0]             grant_idx;
  logic [GW-1:0]             rr_ptr;
  logic                      settle;
  logic [C_NUM_PE-1:0]       head;
  logic [C_NUM_PE-1:0]       head_gnt;
  logic [C_NUM_PE-1:0]       drop_gnt;
  logic [GW-1:0]             head_idx;
  logic [GW-1:0]             drop_idx;
  logic                      head_any;
  logic                      drop_any;
  logic                      load_ok;
  logic                      load;
  logic                      drop_fire;
  logic [GW-1:0]             sel_idx;
  logic [C_PACKET_WIDTH-1:0] sel_flit;
  logic                      unused_drop_idx;

  always_comb begin
    head = '0;
    for (int i = 0; i < C_NUM_PE; i++)
      head[i] = pe_output_data[C_PACKET_WIDTH*i + C_PKT_HEAD_BIT];
  end

  cnn_layer_accel_rr_arb #(.N(C_NUM_PE), .IW(GW)) u_head_arb (
    .req   (pe_output_valid & head),
    .ptr   (rr_ptr),
    .grant (head_gnt),
    .idx   (head_idx),
    .any   (head_any)
  );

  cnn_layer_accel_rr_arb #(.N(C_NUM_PE), .IW(GW)) u_drop_arb (
    .req   (pe_output_valid & ~head),
    .ptr   (rr_ptr),
    .grant (drop_gnt),
    .idx   (drop_idx),
    .any   (drop_any)
  );

  assign unused_drop_idx = ^drop_idx;
  assign load_ok         = ~arb_output_valid | arb_output_accept;

  // settle blocks arbitration for the cycle after a multi-flit packet releases the lock
  always_comb begin
    pe_output_accept = '0;
    load             = 1'b0;
    drop_fire        = 1'b0;
    sel_idx          = grant_idx;
    if (lock == LOCK_LOCKED) begin
      if (load_ok && pe_output_valid[grant_idx]) begin
        pe_output_accept[grant_idx] = 1'b1;
        load                        = 1'b1;
      end
    end else if (!settle) begin
      if (head_any) begin
        sel_idx = head_idx;
        if (load_ok) begin
          pe_output_accept = head_gnt;
          load             = 1'b1;
        end
      end else if (drop_any) begin
        pe_output_accept = drop_gnt;
        drop_fire        = 1'b1;
      end
    end
  end

  assign sel_flit = pe_output_data[C_PACKET_WIDTH*int'(sel_idx) +: C_PACKET_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock             <= LOCK_IDLE;
      grant_idx        <= '0;
      rr_ptr           <= GW'(C_NUM_PE - 1);
      settle           <= 1'b0;
      arb_output_valid <= 1'b0;
      arb_output_data  <= '0;
      arb_output_grant <= '0;
      arb_err_no_head  <= 1'b0;
    end else begin
      settle <= 1'b0;
      if (arb_output_valid && arb_output_accept)
        arb_output_valid <= 1'b0;
      if (load) begin
        arb_output_valid <= 1'b1;
        arb_output_data  <= sel_flit;
        arb_output_grant <= sel_idx;
      end
      if (drop_fire)
        arb_err_no_head <= 1'b1;
      case (lock)
        LOCK_IDLE: begin
          if (load) begin
            grant_idx <= sel_idx;
            if (sel_flit[C_PKT_TAIL_BIT]) rr_ptr <= sel_idx;
            else                          lock   <= LOCK_LOCKED;
          end
        end
        LOCK_LOCKED: begin
          if (load && sel_flit[C_PKT_TAIL_BIT]) begin
            lock   <= LOCK_IDLE;
            rr_ptr <= grant_idx;
            settle <= 1'b1;
          end
        end
        default: lock <= LOCK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_pe_output_arbiter.sv
// tb/tb_cnn_layer_accel_pe_output_arbiter.sv - directed and random checks against a packet-level lane model
module tb_cnn_layer_accel_pe_output_arbiter;

  localparam int W = 66;
  localparam int N = 4;
  typedef logic [W-1:0] flit_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   pe_valid;
  logic [N-1:0]   pe_acc;
  logic [W*N-1:0] pe_data;
  logic           arb_v;
  logic           arb_acc;
  logic [W-1:0]   arb_d;
  logic [1:0]     arb_g;
  logic           err;

  cnn_layer_accel_pe_output_arbiter #(.C_PACKET_WIDTH(W), .C_NUM_PE(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .pe_output_valid   (pe_valid),
    .pe_output_accept  (pe_acc),
    .pe_output_data    (pe_data),
    .arb_output_valid  (arb_v),
    .arb_output_accept (arb_acc),
    .arb_output_data   (arb_d),
    .arb_output_grant  (arb_g),
    .arb_err_no_head   (err)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  flit_t    lq[N][$];
  flit_t    exp_q[$];
  int       exp_lane[$];
  int       out_cyc[$];
  int       out_lane[$];
  bit       m_locked, m_gap, err_exp, prev_stall;
  int       m_lane, m_last;
  flit_t    prev_d;
  bit       ds_rand, ds_val;
  logic [N-1:0] last_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic flit_t mk(input bit h, input bit t, input logic [63:0] p);
    return {h, t, p};
  endfunction

  // first requesting lane after the last lane that finished a packet
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (lq[i].size() > 0) return 1'b1;
    return (exp_q.size() != 0) || (arb_v === 1'b1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) lq[i].delete();
    exp_q.delete();
    exp_lane.delete();
    m_locked = 0; m_gap = 0; m_lane = 0; m_last = N - 1;
    err_exp = 0; prev_stall = 0;
  endtask

  task automatic step();
    logic [N-1:0] hv, nv, xfer;
    bit    load_ok, fwd;
    int    lane_x;
    flit_t f;
    fwd = 0; lane_x = -1; f = '0;
    for (int i = 0; i < N; i++) begin
      hv[i] = 1'b0; nv[i] = 1'b0;
      pe_valid[i] = (lq[i].size() > 0);
      pe_data[W*i +: W] = '0;
      if (pe_valid[i]) begin
        pe_data[W*i +: W] = lq[i][0];
        hv[i] = lq[i][0][W-1];
        nv[i] = ~lq[i][0][W-1];
      end
    end
    arb_acc = ds_rand ? ($urandom_range(0, 9) < 7) : ds_val;
    #1;
    last_acc = pe_acc;
    xfer = pe_valid & pe_acc;
    if (!rst) begin
      load_ok = !arb_v || arb_acc;
      chk("err_sticky", err, err_exp);
      chk("accept_onehot", ($countones(xfer) <= 1), 1);
      if (prev_stall) begin
        chk("hold_valid", arb_v, 1);
        chk("hold_data", arb_d, prev_d);
      end
      if (arb_v && arb_acc) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          chk("out_data", arb_d, exp_q.pop_front());
          chk("out_lane", arb_g, exp_lane.pop_front());
          out_cyc.push_back(cyc);
          out_lane.push_back(int'(arb_g));
        end
      end
      if (m_gap) chk("boundary_bubble", xfer, 0);
      else if (!m_locked) begin
        if ((hv != 0 && load_ok) || (hv == 0 && nv != 0)) chk("idle_progress", (xfer != 0), 1);
      end else if (pe_valid[m_lane] && load_ok) chk("locked_progress", xfer[m_lane], 1);
      m_gap = 0;
      for (int i = 0; i < N; i++) if (xfer[i]) lane_x = i;
      if (lane_x >= 0) begin
        f = lq[lane_x][0];
        if (m_locked) begin
          chk("locked_lane", lane_x, m_lane);
          fwd = 1;
          if (f[W-2]) begin m_locked = 0; m_last = lane_x; m_gap = 1; end
        end else if (f[W-1]) begin
          chk("rr_head_pick", lane_x, rr_pick(hv, m_last));
          fwd = 1;
          if (f[W-2]) m_last = lane_x;
          else begin m_locked = 1; m_lane = lane_x; end
        end else begin
          chk("rr_drop_pick", lane_x, rr_pick(nv, m_last));
          err_exp = 1;
        end
        if (fwd) begin exp_q.push_back(f); exp_lane.push_back(lane_x); end
      end
      prev_stall = arb_v && !arb_acc;
      prev_d = arb_d;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else if (lane_x >= 0) begin
      void'(lq[lane_x].pop_front());
      if (fwd) begin
        chk("latency_valid", arb_v, 1);
        chk("latency_data", arb_d, f);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (busy() && n < limit) begin step(); n++; end
    chk("drain_timeout", busy(), 0);
  endtask

  task automatic clear_log();
    out_cyc.delete();
    out_lane.delete();
  endtask

  initial begin
    rst = 1'b1; pe_valid = '0; pe_data = '0; arb_acc = 1'b0;
    ds_rand = 0; ds_val = 1; last_acc = '0;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    repeat (3) begin
      step();
      chk("rst_valid", arb_v, 0);
      chk("rst_data", arb_d, 0);
      chk("rst_grant", arb_g, 0);
      chk("rst_err", err, 0);
      chk("rst_accept", last_acc, 0);
    end

    clear_log();
    for (int i = 0; i < N; i++) lq[i].push_back(mk(1, 1, 64'(i)));
    drain(50);
    chk("single_count", out_lane.size(), 4);
    if (out_lane.size() == 4)
      for (int i = 0; i < N; i++) begin
        chk("single_order", out_lane[i], i);
        chk("single_back2back", out_cyc[i] - out_cyc[0], i);
      end

    clear_log();
    lq[2].push_back(mk(1, 0, 64'd20));
    lq[2].push_back(mk(0, 0, 64'd21));
    lq[2].push_back(mk(0, 0, 64'd22));
    lq[2].push_back(mk(0, 1, 64'd23));
    step();
    lq[1].push_back(mk(1, 1, 64'd10));
    drain(50);
    chk("pkt_count", out_lane.size(), 5);
    if (out_lane.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("pkt_lane2", out_lane[i], 2);
      chk("pkt_then_lane1", out_lane[4], 1);
      chk("pkt_contiguous", out_cyc[3] - out_cyc[0], 3);
      chk("pkt_bubble", out_cyc[4] - out_cyc[3], 2);
    end

    clear_log();
    lq[0].push_back(mk(1, 0, 64'd40));
    lq[0].push_back(mk(0, 0, 64'd41));
    lq[0].push_back(mk(0, 0, 64'd42));
    lq[0].push_back(mk(0, 1, 64'd43));
    step(); step();
    ds_val = 0;
    repeat (5) begin
      step();
      chk("stall_accept", last_acc, 0);
      chk("stall_data", arb_d, mk(0, 0, 64'd41));
    end
    ds_val = 1;
    drain(50);
    chk("stall_count", out_lane.size(), 4);

    lq[3].push_back(mk(0, 1, 64'h55));
    step();
    chk("drop_accept", last_acc, 4'b1000);
    chk("drop_err", err, 1);
    chk("drop_no_output", arb_v, 0);
    chk("drop_gone", lq[3].size(), 0);
    repeat (3) step();
    chk("drop_err_sticky", err, 1);

    lq[1].push_back(mk(1, 0, 64'd60));
    lq[1].push_back(mk(0, 0, 64'd61));
    lq[1].push_back(mk(0, 1, 64'd62));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", arb_v, 0);
    chk("midrst_data", arb_d, 0);
    chk("midrst_grant", arb_g, 0);
    chk("midrst_err", err, 0);
    clear_log();
    lq[0].push_back(mk(1, 1, 64'd70));
    lq[2].push_back(mk(1, 1, 64'd72));
    drain(50);
    chk("midrst_count", out_lane.size(), 2);
    if (out_lane.size() == 2) begin
      chk("midrst_first", out_lane[0], 0);
      chk("midrst_second", out_lane[1], 2);
    end

    ds_rand = 1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (lq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) == 0)
            lq[i].push_back(mk(0, $urandom_range(0, 1) == 1, {16'(i), 48'(c), 1'b0}));
          else begin
            int len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
              lq[i].push_back(mk(k == 0, k == len - 1, {16'(i), 32'(c), 16'(k)}));
          end
        end
      end
      step();
    end
    ds_rand = 0;
    ds_val = 1;
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
